// File: rtl/pacman_life_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pacman_life_ctrl                                              |
// | Purpose  : Life / death / respawn controller for Pac-Man.                |
// |            Samples ghost collisions once per frame, runs the death       |
// |            animation timer and post-respawn immunity, and optionally     |
// |            scores eaten ghosts with 200/400/800/1600 escalation.         |
// | Macro    : PACMAN_GHOST_EAT_EN - when defined, ghost eating is built in; |
// |            when undefined every qualifying collision is a death.         |
// | Ports    : clk, rst_n (async, active low)                                |
// |            col[3:0]       per-ghost collision flags                      |
// |            frame_tick     one pulse per video frame                      |
// |            start          level-sampled start request                    |
// |            power_active   Pac-Man energized                              |
// |            lives[2:0]     remaining lives                                |
// |            freeze         movement halted (all states except PLAY)       |
// |            respawn        one-cycle return-to-start command              |
// |            game_over      high in GAMEOVER                               |
// |            ghost_eaten    one-hot pulse naming the eaten ghost           |
// |            score_add      points for the current eat                     |
// |            score_valid    one-cycle pulse qualifying score_add           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pacman_life_ctrl #(
    parameter int LIVES_INIT    = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        power_active,
    output logic [2:0]  lives,
    output logic        freeze,
    output logic        respawn,
    output logic        game_over,
    output logic [3:0]  ghost_eaten,
    output logic [10:0] score_add,
    output logic        score_valid
);

    localparam logic [2:0] c_lives_init  = 3'(LIVES_INIT);
    localparam logic [7:0] c_death_load  = 8'(DEATH_FRAMES);
    localparam logic [7:0] c_invuln_load = 8'(INVULN_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_DYING    = 3'd2,
        S_RESPAWN  = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_lives;
    logic [7:0] r_death_cnt;
    logic [7:0] r_invuln_cnt;

    logic w_sample;      // collision sampling window for this cycle
    logic w_hit;         // qualifying collision that kills Pac-Man
    logic w_eat;         // qualifying collision that eats a ghost
    logic w_death_done;  // last frame of the death animation
    logic w_new_game;    // start accepted in IDLE or GAMEOVER

    assign w_sample     = frame_tick && (r_state == S_PLAY) && (r_invuln_cnt == 8'd0);
    assign w_death_done = (r_state == S_DYING) && frame_tick && (r_death_cnt == 8'd1);
    assign w_new_game   = start && ((r_state == S_IDLE) || (r_state == S_GAMEOVER));

`ifdef PACMAN_GHOST_EAT_EN
    logic [3:0] r_eaten_mask;  // ghosts already eaten during this power period
    logic [1:0] r_mult_idx;
    logic [3:0] w_col_live;
    logic [3:0] w_lowest;

    // An eaten ghost stays harmless until the power period ends, so its
    // collision bit is hidden while power is active.
    assign w_col_live = power_active ? (col & ~r_eaten_mask) : col;
    assign w_lowest   = w_col_live & (~w_col_live + 4'd1);
    assign w_eat      = w_sample && power_active && (w_col_live != 4'd0);
    assign w_hit      = w_sample && !power_active && (w_col_live != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghost_eaten  <= 4'd0;
            score_add    <= 11'd0;
            score_valid  <= 1'b0;
            r_mult_idx   <= 2'd0;
            r_eaten_mask <= 4'd0;
        end else begin
            ghost_eaten <= 4'd0;
            score_add   <= 11'd0;
            score_valid <= 1'b0;
            if (!power_active || w_new_game) begin
                r_mult_idx   <= 2'd0;
                r_eaten_mask <= 4'd0;
            end else if (w_eat) begin
                ghost_eaten  <= w_lowest;
                score_add    <= 11'd200 << r_mult_idx;
                score_valid  <= 1'b1;
                r_eaten_mask <= r_eaten_mask | w_lowest;
                if (r_mult_idx != 2'd3) begin
                    r_mult_idx <= r_mult_idx + 2'd1;
                end
            end
        end
    end
`else
    logic unused_power_active;

    assign unused_power_active = power_active;
    assign w_eat       = 1'b0;
    assign w_hit       = w_sample && (col != 4'd0);
    assign ghost_eaten = 4'd0;
    assign score_add   = 11'd0;
    assign score_valid = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        freeze      = 1'b1;
        respawn     = 1'b0;
        game_over   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                freeze = 1'b0;
                if (w_hit) w_state_nxt = S_DYING;
            end
            S_DYING: begin
                if (w_death_done) begin
                    w_state_nxt = (r_lives != 3'd0) ? S_RESPAWN : S_GAMEOVER;
                end
            end
            S_RESPAWN: begin
                respawn     = 1'b1;
                w_state_nxt = S_PLAY;
            end
            S_GAMEOVER: begin
                game_over = 1'b1;
                if (start) w_state_nxt = S_PLAY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lives and frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lives      <= c_lives_init;
            r_death_cnt  <= 8'd0;
            r_invuln_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_GAMEOVER: begin
                    if (start) begin
                        r_lives      <= c_lives_init;
                        r_invuln_cnt <= 8'd0;
                    end
                end
                S_PLAY: begin
                    // PLAY is only entered with lives>0, so this cannot wrap.
                    if (w_hit) begin
                        r_lives     <= r_lives - 3'd1;
                        r_death_cnt <= c_death_load;
                    end else if (frame_tick && (r_invuln_cnt != 8'd0)) begin
                        r_invuln_cnt <= r_invuln_cnt - 8'd1;
                    end
                end
                S_DYING: begin
                    if (frame_tick && (r_death_cnt != 8'd0)) begin
                        r_death_cnt <= r_death_cnt - 8'd1;
                    end
                end
                S_RESPAWN: begin
                    r_invuln_cnt <= c_invuln_load;
                end
                default: ;
            endcase
        end
    end

    assign lives = r_lives;

endmodule
`default_nettype wire

// File: doc/pacman_life_ctrl.md
PACMAN_LIFE_CTRL -- requirements
Module: pacman_life_ctrl

Interface
REQ-001 The block SHALL have parameter LIVES_INIT, default 3, giving the lives loaded on reset and on start (range 1-7).
REQ-002 The block SHALL have parameter DEATH_FRAMES, default 60, giving the length of the death animation in frame ticks (1-255).
REQ-003 The block SHALL have parameter INVULN_FRAMES, default 90, giving the frame ticks of collision immunity after respawn (0-255).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset. Both port names below are fixed.
REQ-005 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 col  in  4  per-ghost collision flags from the four collision_detection instances (bit i = ghost i).
REQ-008 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-009 start  in  1  level-sampled start request.
REQ-010 power_active  in  1  high while Pac-Man is energized.
REQ-011 lives  out  3  remaining lives.
REQ-012 freeze  out  1  high while gameplay movement SHALL halt.
REQ-013 respawn  out  1  one-cycle pulse commanding the actors to return to their start positions.
REQ-014 game_over  out  1  high in the GAMEOVER state.
REQ-015 ghost_eaten  out  4  one-hot, one-cycle pulse naming the eaten ghost.
REQ-016 score_add  out  11  points for the current eat; valid only when score_valid is high.
REQ-017 score_valid  out  1  one-cycle pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, PLAY, DYING, RESPAWN and GAMEOVER.
REQ-019 In IDLE, with freeze=1: when start=1, the FSM SHALL load lives=LIVES_INIT, clear invuln_cnt and enter PLAY on the next edge.
REQ-020 The FSM SHALL sample col only on cycles where frame_tick=1, the state is PLAY and invuln_cnt=0. Otherwise col SHALL be ignored.
REQ-021 A qualifying sample with col!=0 and no eat (REQ-026) SHALL cause a death.
  - lives decrements by 1.
  - The state becomes DYING on the same edge, and freeze=1 from the next cycle.
  - Several simultaneous col bits SHALL count as exactly one death.
REQ-022 DYING SHALL last exactly DEATH_FRAMES frame_tick pulses, counted by an 8-bit down-counter.
  - On expiry with lives>0: go to RESPAWN.
  - On expiry with lives=0: go to GAMEOVER.
REQ-023 RESPAWN SHALL last one cycle.
  - respawn=1 during it.
  - invuln_cnt loads INVULN_FRAMES.
  - The next state is PLAY.
REQ-024 In PLAY, invuln_cnt SHALL decrement on each frame_tick while it is non-zero, and SHALL saturate at 0.
REQ-025 GAMEOVER SHALL hold freeze=1 and game_over=1 until start=1, which SHALL act exactly as REQ-019.
REQ-026 An eat SHALL occur when power_active=1 on a qualifying sample and the eat feature is compiled in (REQ-033).
  - Only the lowest-index set bit of col is eaten per sample; the remaining bits are re-evaluated on later frame_ticks.
  - ghost_eaten, score_add and score_valid SHALL be registered and appear the cycle after the sample.
REQ-027 Eat scores SHALL escalate within one power period: 200, 400, 800, then 1600.
  - A 2-bit multiplier index holds the position and saturates at 1600.
  - The index SHALL reset to 0 whenever power_active=0.
REQ-028 lives SHALL never underflow.
  - A collision is only sampled in PLAY, which is only entered with lives>0.
REQ-029 freeze SHALL be 1 in IDLE, DYING, RESPAWN and GAMEOVER, and 0 only in PLAY.

Reset
REQ-030 While rst_n=0, regardless of clk, the block SHALL force the following:
  - state=IDLE and lives=LIVES_INIT.
  - All counters = 0.
  - freeze=1.
  - respawn, game_over, ghost_eaten, score_add and score_valid = 0.
REQ-031 Reset asserted mid-DYING or mid-eat SHALL abort the operation with no residual pulse after release.
REQ-032 After rst_n rises, the first state change SHALL occur no earlier than the next rising edge of clk.

Configuration
REQ-033 The macro PACMAN_GHOST_EAT_EN SHALL control ghost eating.
  - Defined: REQ-026 and REQ-027 apply.
  - Undefined: power_active SHALL be ignored, every qualifying col!=0 SHALL be a death, and ghost_eaten, score_add and score_valid SHALL be tied to 0.

Verification
REQ-034 Eat-disabled build: reset, start=1 for 1 cycle, col=4'b0010 on a frame_tick. Required response:
  - lives goes 3->2, freeze=1.
  - After 60 ticks, respawn pulses once and the state returns to PLAY.
REQ-035 Invulnerability: immediately after respawn, hold col=4'b1111 for 90 frame_ticks. Required response:
  - lives is unchanged.
  - On the 91st tick, lives decrements.
REQ-036 Game over: with LIVES_INIT=1, collide once. Required response:
  - game_over=1 after 60 ticks.
  - start=1 then restores lives=1 and the PLAY state.
REQ-037 Eat-enabled build: power_active=1, col=4'b0101 held for 3 ticks. Required response:
  - ghost_eaten=0001 with score 200.
  - Then ghost_eaten=0100 with score 400.
  - No death.
  - Dropping power_active, then eating again, gives score 200.
REQ-038 Reset mid-operation: assert rst_n=0 at DYING tick 30. Required response:
  - Outputs take their reset values immediately and asynchronously.
  - No respawn pulse follows release.
